// File: rtl/systolic_drain_ctrl.sv
// Drain sequencer for a systolic array: issues row shifts, then re-aligns them
// with the lane-0 deskew latency to produce output-buffer writes.
module systolic_drain_ctrl #(
  parameter int ARRAY      = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  num_rows,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic                  pause,
  output logic                  drain_en,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic                  busy,
  output logic                  done
);

  localparam int FW = (ARRAY > 1) ? $clog2(ARRAY) : 1;
  localparam logic [FW-1:0]        FLUSH_LAST = FW'(ARRAY - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);

  typedef enum logic [1:0] {IDLE, DRAIN, FLUSH, DONE} state_e;

  typedef struct packed {
    logic [CNT_WIDTH-1:0]  rows;
    logic [ADDR_WIDTH-1:0] base;
  } job_t;

  state_e                state_q, state_d;
  job_t                  job_q;
  logic [CNT_WIDTH-1:0]  issued_q, issued_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [FW-1:0]         flush_q, flush_d;
  logic [ARRAY-1:0]      vld_q;

  logic start_ok;
  logic last_row;

  assign start_ok = start && (state_q == IDLE);
  assign last_row = ((issued_q + CNT_ONE) == job_q.rows);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (start) state_d = (num_rows == '0) ? DONE : DRAIN;
      DRAIN: if (drain_en && last_row) state_d = FLUSH;
      FLUSH: if (flush_q == FLUSH_LAST) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs; drain_en is gated by reset so a row shifted during reset is never lost silently
  always_comb begin
    drain_en = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_q)
      IDLE:  busy = 1'b0;
      DRAIN: begin
        busy     = 1'b1;
        drain_en = !pause && !reset && (issued_q != job_q.rows);
      end
      FLUSH: busy = 1'b1;
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: busy = 1'b0;
    endcase
  end

  always_comb begin
    issued_d = issued_q;
    addr_d   = addr_q;
    flush_d  = '0;
    if (start_ok) begin
      issued_d = '0;
      addr_d   = base_addr;
    end else begin
      if (drain_en)  issued_d = issued_q + CNT_ONE;
      if (mem_wr_en) addr_d   = addr_q + ADDR_WIDTH'(1);
    end
    if (state_q == FLUSH) flush_d = flush_q + FW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      job_q    <= '0;
      issued_q <= '0;
      addr_q   <= '0;
      flush_q  <= '0;
    end else begin
      if (start_ok) begin
        job_q.rows <= num_rows;
        job_q.base <= base_addr;
      end
      issued_q <= issued_d;
      addr_q   <= addr_d;
      flush_q  <= flush_d;
    end
  end

  // Valid pipeline mirroring the lane-0 deskew depth
  genvar gi;
  generate
    for (gi = 0; gi < ARRAY; gi++) begin : g_vld
      always_ff @(posedge clk) begin
        if (reset)        vld_q[gi] <= 1'b0;
        else if (gi == 0) vld_q[gi] <= drain_en;
        else              vld_q[gi] <= vld_q[(gi == 0) ? 0 : gi - 1];
      end
    end
  endgenerate

  assign mem_wr_en   = vld_q[ARRAY-1];
  assign mem_wr_addr = addr_q;

endmodule

// File: tb/tb_systolic_drain_ctrl.sv
// Scoreboard bench: stimulus pushes expected drain/write/done events with their
// cycle numbers; a negedge monitor pops and compares as the DUT produces them.
module tb_systolic_drain_ctrl;
  localparam int A = 4;

  logic        clk = 1'b0;
  logic        reset, start, start_w, pause;
  logic [15:0] num_rows;
  logic [9:0]  base_addr;
  logic [3:0]  base_w;
  logic        drain_en, mem_wr_en, busy, done;
  logic [9:0]  mem_wr_addr;
  logic        drain_en_w, mem_wr_en_w, busy_w, done_w;
  logic [3:0]  mem_wr_addr_w;

  systolic_drain_ctrl #(.ARRAY(A), .ADDR_WIDTH(10), .CNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .start(start), .num_rows(num_rows),
    .base_addr(base_addr), .pause(pause), .drain_en(drain_en),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .busy(busy), .done(done)
  );

  systolic_drain_ctrl #(.ARRAY(A), .ADDR_WIDTH(4), .CNT_WIDTH(16)) dut_w (
    .clk(clk), .reset(reset), .start(start_w), .num_rows(num_rows),
    .base_addr(base_w), .pause(pause), .drain_en(drain_en_w),
    .mem_wr_en(mem_wr_en_w), .mem_wr_addr(mem_wr_addr_w), .busy(busy_w), .done(done_w)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  typedef struct { int cyc; int addr; } wr_t;
  wr_t exp_wr[$];
  wr_t exp_wr_w[$];
  int  exp_drain[$];
  int  exp_done[$];
  int  exp_done_w[$];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    wr_t e;
    if (drain_en === 1'b1) begin
      if (exp_drain.size() == 0) chk("drain_unexpected", cyc, 32'hFFFF_FFFF);
      else chk("drain_cycle", cyc, exp_drain.pop_front());
    end
    if (mem_wr_en === 1'b1) begin
      if (exp_wr.size() == 0) chk("wr_unexpected", cyc, 32'hFFFF_FFFF);
      else begin
        e = exp_wr.pop_front();
        chk("wr_cycle", cyc, e.cyc);
        chk("wr_addr", {22'd0, mem_wr_addr}, e.addr);
      end
    end
    if (done === 1'b1) begin
      if (exp_done.size() == 0) chk("done_unexpected", cyc, 32'hFFFF_FFFF);
      else chk("done_cycle", cyc, exp_done.pop_front());
    end
    if (mem_wr_en_w === 1'b1) begin
      if (exp_wr_w.size() == 0) chk("wrap_wr_unexpected", cyc, 32'hFFFF_FFFF);
      else begin
        e = exp_wr_w.pop_front();
        chk("wrap_wr_cycle", cyc, e.cyc);
        chk("wrap_wr_addr", {28'd0, mem_wr_addr_w}, e.addr);
      end
    end
    if (done_w === 1'b1) begin
      if (exp_done_w.size() == 0) chk("wrap_done_unexpected", cyc, 32'hFFFF_FFFF);
      else chk("wrap_done_cycle", cyc, exp_done_w.pop_front());
    end
  end

  task automatic goto(int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Unpaused job started in cycle c: drains c+1.., writes A cycles later, done after ARRAY flush cycles
  task automatic exp_job(int c, int rows, int base);
    wr_t e;
    for (int i = 0; i < rows; i++) begin
      exp_drain.push_back(c + 1 + i);
      e.cyc  = c + 1 + i + A;
      e.addr = (base + i) & 10'h3FF;
      exp_wr.push_back(e);
    end
    exp_done.push_back(c + rows + 1 + A);
  endtask

  task automatic pulse_start(int rows, int base);
    start     = 1'b1;
    num_rows  = 16'(rows);
    base_addr = 10'(base);
    goto(cyc + 1);
    start = 1'b0;
  endtask

  task automatic chk_idle(string tag);
    chk({tag, "_drain_en"}, {31'd0, drain_en}, 0);
    chk({tag, "_mem_wr_en"}, {31'd0, mem_wr_en}, 0);
    chk({tag, "_busy"}, {31'd0, busy}, 0);
    chk({tag, "_done"}, {31'd0, done}, 0);
    chk({tag, "_addr"}, {22'd0, mem_wr_addr}, 0);
  endtask

  initial begin
    int c;
    wr_t e;
    reset = 1'b1; start = 1'b0; start_w = 1'b0; pause = 1'b0;
    num_rows = '0; base_addr = '0; base_w = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk_idle("reset");

    // 3 rows from 0x10: drains c+1..c+3, writes c+5..c+7, done c+8
    c = cyc;
    exp_job(c, 3, 'h10);
    pulse_start(3, 'h10);
    chk("busy_after_start", {31'd0, busy}, 1);
    goto(c + 9);
    chk("idle_after_done", {31'd0, busy}, 0);

    // Back-to-back start in the cycle after DONE, with a 2-cycle pause after the second drain
    c = cyc;
    exp_drain.push_back(c + 1); exp_drain.push_back(c + 2);
    exp_drain.push_back(c + 5); exp_drain.push_back(c + 6);
    e.cyc = c + 5;  e.addr = 'h100; exp_wr.push_back(e);
    e.cyc = c + 6;  e.addr = 'h101; exp_wr.push_back(e);
    e.cyc = c + 9;  e.addr = 'h102; exp_wr.push_back(e);
    e.cyc = c + 10; e.addr = 'h103; exp_wr.push_back(e);
    exp_done.push_back(c + 11);
    pulse_start(4, 'h100);
    goto(c + 3); pause = 1'b1;
    goto(c + 5); pause = 1'b0;
    goto(c + 12);
    chk("pause_job_idle", {31'd0, busy}, 0);

    // Zero rows: straight to DONE
    c = cyc;
    exp_done.push_back(c + 1);
    pulse_start(0, 'h55);
    chk("zero_busy", {31'd0, busy}, 1);
    chk("zero_done", {31'd0, done}, 1);
    goto(c + 2);
    chk("zero_idle", {31'd0, busy}, 0);

    // Starts while busy are ignored
    c = cyc;
    exp_job(c, 3, 'h20);
    pulse_start(3, 'h20);
    goto(c + 2); start = 1'b1; num_rows = 16'd9; base_addr = 10'h80;
    goto(c + 3); start = 1'b0;
    goto(c + 5); start = 1'b1;
    goto(c + 6); start = 1'b0;
    goto(c + 9);
    chk("ignored_start_idle", {31'd0, busy}, 0);

    // Reset (together with start) after two drains of an 8-row job
    c = cyc;
    exp_drain.push_back(c + 1); exp_drain.push_back(c + 2);
    pulse_start(8, 'h30);
    goto(c + 3); reset = 1'b1; start = 1'b1; num_rows = 16'd5;
    goto(c + 4); reset = 1'b0; start = 1'b0;
    chk_idle("midreset");
    goto(c + 16);

    // New job after reset, wrapping the 10-bit address
    c = cyc;
    exp_job(c, 2, 'h3FF);
    pulse_start(2, 'h3FF);
    goto(c + 2 + A + 3);

    // 4-bit address instance wraps 0xE, 0xF, 0x0
    c = cyc;
    e.cyc = c + 5; e.addr = 'hE; exp_wr_w.push_back(e);
    e.cyc = c + 6; e.addr = 'hF; exp_wr_w.push_back(e);
    e.cyc = c + 7; e.addr = 'h0; exp_wr_w.push_back(e);
    exp_done_w.push_back(c + 8);
    start_w = 1'b1; num_rows = 16'd3; base_w = 4'hE;
    goto(c + 1); start_w = 1'b0;
    goto(c + 12);

    chk("left_drain", exp_drain.size(), 0);
    chk("left_wr", exp_wr.size(), 0);
    chk("left_done", exp_done.size(), 0);
    chk("left_wr_w", exp_wr_w.size(), 0);
    chk("left_done_w", exp_done_w.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
